seq_slt_unit: RTL and testbench



---
 rtl/seq_slt_unit_pkg.sv | 33 +++
 rtl/seq_slt_unit_slice_cmp.sv | 15 +
 rtl/seq_slt_unit.sv | 118 +++++++++++
 tb/tb_seq_slt_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seq_slt_unit_pkg.sv
// Shared definitions for the sliced set-on-compare unit: mode encodings,
// FSM state type and the helpers that form the final flag.
package cmp_pkg;

  localparam logic [1:0] CMP_SLT  = 2'b00;
  localparam logic [1:0] CMP_SLTU = 2'b01;
  localparam logic [1:0] CMP_SEQ  = 2'b10;
  localparam logic [1:0] CMP_SLE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_t;

  // Signed modes are handled by flipping the sign bit so every slice compares unsigned.
  function automatic logic is_signed_mode(input logic [1:0] mode);
    return (mode == CMP_SLT) || (mode == CMP_SLE);
  endfunction

  function automatic logic form_flag(input logic [1:0] mode,
                                     input logic       lt,
                                     input logic       decided);
    logic flag;
    unique case (mode)
      CMP_SLT, CMP_SLTU: flag = lt;
      CMP_SEQ:           flag = !decided;
      default:           flag = lt | !decided;
    endcase
    return flag;
  endfunction

endpackage

// File: rtl/seq_slt_unit_slice_cmp.sv
// One slice of the MSB-first magnitude compare: flags inequality and
// unsigned less-than for a single SLICE-wide operand pair.
module slice_cmp #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             neq_o,
  output logic             lt_o
);

  assign neq_o = (a_i != b_i);
  assign lt_o  = (a_i < b_i);

endmodule

// File: rtl/seq_slt_unit.sv
// Multi-cycle SLT/SLTU/SEQ/SLE unit: compares SLICE bits per cycle, MSB slice
// first; the first differing slice decides the ordering.
module seq_slt_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [WIDTH-1:0] SIGN_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("seq_slt_unit: SLICE must divide WIDTH");
  end

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [1:0]       mode_q, mode_d;
  logic             lt_q, lt_d;
  logic             decided_q, decided_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic slc_neq, slc_lt;
  logic lt_upd, decided_upd;
  logic capture;

  slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
    .a_i   (sa_q[WIDTH-1 -: SLICE]),
    .b_i   (sb_q[WIDTH-1 -: SLICE]),
    .neq_o (slc_neq),
    .lt_o  (slc_lt)
  );

  // Once a slice has differed, later (less significant) slices cannot change the outcome.
  assign lt_upd      = decided_q ? lt_q : (slc_neq ? slc_lt : lt_q);
  assign decided_upd = decided_q | slc_neq;
  assign capture     = start && (state_q != ST_BUSY);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    mode_d    = mode_q;
    lt_d      = lt_q;
    decided_d = decided_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: begin
        lt_d      = lt_upd;
        decided_d = decided_upd;
        sa_d      = sa_q << SLICE;
        sb_d      = sb_q << SLICE;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d  = ST_DONE;
          result_d = {{(WIDTH-1){1'b0}}, form_flag(mode_q, lt_upd, decided_upd)};
        end
      end
      ST_DONE: state_d = start ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      sa_d      = is_signed_mode(mode) ? (a ^ SIGN_MSB) : a;
      sb_d      = is_signed_mode(mode) ? (b ^ SIGN_MSB) : b;
      mode_d    = mode;
      lt_d      = 1'b0;
      decided_d = 1'b0;
      cnt_d     = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      mode_q    <= CMP_SLT;
      lt_q      <= 1'b0;
      decided_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      mode_q    <= mode_d;
      lt_q      <= lt_d;
      decided_q <= decided_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == ST_BUSY);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_seq_slt_unit.sv
// Directed bench for seq_slt_unit: a vector table on the 32/8 instance plus
// hand-timed sequences for reset, back-to-back issue, abort and a 16/4 instance.
module tb_seq_slt_unit;
  import cmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  logic        start16;
  logic [1:0]  mode16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [15:0] result16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_slt_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  seq_slt_unit #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16)
  );

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op on the 32-bit instance and verify the full N+1 cycle timeline.
  task automatic run_op(input string name, input logic [1:0] m,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp);
    @(negedge clk);
    start = 1'b1; mode = m; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; mode = 2'bxx; a = 'x; b = 'x;
    for (int k = 1; k <= 4; k++) begin
      check({name, " busy"}, {30'd0, busy, done}, 32'b10);
      if (k < 4) @(negedge clk);
    end
    @(negedge clk);
    check({name, " done"}, {30'd0, busy, done}, 32'b01);
    check({name, " result"}, result, exp);
  endtask

  initial begin
    vecs[0]  = '{"slt_neg2_3",     CMP_SLT,  32'hFFFF_FFFE, 32'h0000_0003, 32'h1};
    vecs[1]  = '{"sltu_neg2_3",    CMP_SLTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0};
    vecs[2]  = '{"seq_equal",      CMP_SEQ,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1};
    vecs[3]  = '{"seq_last_slice", CMP_SEQ,  32'hDEAD_BEEE, 32'hDEAD_BEEF, 32'h0};
    vecs[4]  = '{"sle_equal",      CMP_SLE,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1};
    vecs[5]  = '{"slt_min_max",    CMP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
    vecs[6]  = '{"sltu_min_max",   CMP_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0};
    vecs[7]  = '{"slt_equal",      CMP_SLT,  32'h1234_5678, 32'h1234_5678, 32'h0};
    vecs[8]  = '{"sle_5_3",        CMP_SLE,  32'h0000_0005, 32'h0000_0003, 32'h0};
    vecs[9]  = '{"sle_m1_0",       CMP_SLE,  32'hFFFF_FFFF, 32'h0000_0000, 32'h1};
    vecs[10] = '{"seq_first_slice",CMP_SEQ,  32'h0100_0000, 32'h0000_0000, 32'h0};

    rst_n = 1'b0; start = 1'b1; mode = CMP_SLT; a = 32'h1; b = 32'h2;
    start16 = 1'b1; mode16 = CMP_SLT; a16 = 16'h1; b16 = 16'h2;

    // Reset held 3 edges with start asserted: reset must win.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",   {31'd0, busy},   32'd0);
    check("reset done",   {31'd0, done},   32'd0);
    check("reset result", result,          32'd0);
    check("reset16 out",  {15'd0, busy16, done16, result16}, 32'd0);
    start = 1'b0; start16 = 1'b0; rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp);
      if (i == 0) begin
        @(negedge clk);
        check("done one cycle", {30'd0, busy, done}, 32'b00);
        check("result held",    result,              32'h1);
      end
    end

    // Back-to-back: SEQ 1 vs 2 (0), start held through DONE with SLTU 5 vs 9 (1).
    @(negedge clk);
    start = 1'b1; mode = CMP_SEQ; a = 32'd1; b = 32'd2;
    @(negedge clk);                       // t+1
    start = 1'b0;
    @(negedge clk);                       // t+2: stray start during BUSY
    start = 1'b1; mode = CMP_SLTU; a = 32'd0; b = 32'hFFFF_FFFF;
    @(negedge clk);                       // t+3
    start = 1'b0;
    check("b2b busy t+3", {31'd0, busy}, 32'd1);
    @(negedge clk);                       // t+4: keep start high into DONE
    start = 1'b1; mode = CMP_SLTU; a = 32'd5; b = 32'd9;
    @(negedge clk);                       // t+5
    check("b2b first done",   {30'd0, busy, done}, 32'b01);
    check("b2b first result", result,              32'h0);
    @(negedge clk);                       // t+6
    start = 1'b0; mode = 2'bxx; a = 'x; b = 'x;
    for (int k = 6; k <= 9; k++) begin
      check("b2b second busy", {30'd0, busy, done}, 32'b10);
      @(negedge clk);
    end
    check("b2b second done",   {30'd0, busy, done}, 32'b01);
    check("b2b second result", result,              32'h1);

    // Mid-op reset: SLT -2 < 3 would yield 1, reset lands at end of t+2.
    @(negedge clk);
    start = 1'b1; mode = CMP_SLT; a = 32'hFFFF_FFFE; b = 32'h3;
    @(negedge clk);                       // t+1
    start = 1'b0;
    @(negedge clk);                       // t+2
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy",   {31'd0, busy}, 32'd0);
    check("abort result", result,        32'd0);
    begin
      int seen_done = 0;
      for (int k = 0; k < 8; k++) begin
        if (done) seen_done++;
        @(negedge clk);
      end
      check("abort no done",      seen_done, 0);
      check("abort result later", result,    32'd0);
    end

    // 16-bit, 4-bit slice instance: N=4, done at t+5.
    @(negedge clk);
    start16 = 1'b1; mode16 = CMP_SLT; a16 = 16'h0001; b16 = 16'h0000;
    @(negedge clk);
    start16 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("w16 busy", {30'd0, busy16, done16}, 32'b10);
      if (k < 4) @(negedge clk);
    end
    @(negedge clk);
    check("w16 done",   {30'd0, busy16, done16}, 32'b01);
    check("w16 result", {16'd0, result16},       32'h0);

    @(negedge clk);
    start16 = 1'b1; mode16 = CMP_SLT; a16 = 16'h8000; b16 = 16'h0001;
    @(negedge clk);
    start16 = 1'b0;
    repeat (4) @(negedge clk);
    check("w16 slt min done",   {31'd0, done16},   32'd1);
    check("w16 slt min result", {16'd0, result16}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
